// File: rtl/floo_axis_beat_serializer.sv
// floo_axis_beat_serializer: splits one wide AXIS word into NumBeats narrow
// beats, LSB first, with last/index sideband and a zero-bubble reload path.
module floo_axis_beat_serializer #(
  parameter int unsigned DataWidth = 72,
  parameter int unsigned BeatWidth = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [DataWidth-1:0]                  in_data_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [BeatWidth-1:0]                  out_data_o,
  output logic                                  out_last_o,
  output logic [((DataWidth + BeatWidth - 1) / BeatWidth > 1 ?
                 $clog2((DataWidth + BeatWidth - 1) / BeatWidth) : 1)-1:0] out_idx_o,
  output logic                                  busy_o
);

  localparam int unsigned NumBeats  = (DataWidth + BeatWidth - 1) / BeatWidth;
  localparam int unsigned CntWidth  = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned SregWidth = NumBeats * BeatWidth;
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumBeats - 1);

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  state_e               r_state;
  logic [SregWidth-1:0] r_sreg;
  logic [CntWidth-1:0]  r_cnt;
  logic                 r_last;

  logic                 w_out_hs;
  logic                 w_in_hs;
  logic                 w_in_ready;

  // Handshake decode; ready depends on downstream ready only, never on in_valid_i.
  always_comb begin
    w_out_hs   = (r_state == StSend) & out_ready_i;
    w_in_ready = (r_state == StIdle) | (w_out_hs & r_last);
    w_in_hs    = in_valid_i & w_in_ready;
  end

  // State, shift register, beat counter and registered last flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else if (w_in_hs) begin
      // Load from idle or reload on the final beat: beat 0 shows next cycle.
      r_state <= StSend;
      r_sreg  <= SregWidth'(in_data_i);
      r_cnt   <= '0;
      r_last  <= (NumBeats == 1);
    end else if (w_out_hs) begin
      if (r_last) begin
        r_state <= StIdle;
        r_last  <= 1'b0;
      end else begin
        r_sreg  <= r_sreg >> BeatWidth;
        r_cnt   <= r_cnt + CntWidth'(1);
        r_last  <= ((r_cnt + CntWidth'(1)) == LastIdx);
      end
    end
  end

  // Outputs come straight from registers except the ready path.
  always_comb begin
    in_ready_o  = w_in_ready;
    out_valid_o = (r_state == StSend);
    busy_o      = (r_state == StSend);
    out_data_o  = r_sreg[BeatWidth-1:0];
    out_last_o  = r_last;
    out_idx_o   = r_cnt;
  end

endmodule

// File: doc/floo_axis_beat_serializer.md
# floo_axis_beat_serializer

Narrows the wide AXIS word produced by the NoC-to-AXIS bridge (channel header plus flit payload) into a sequence of fixed-width beats for the serial link's narrower physical channel. It sits directly downstream of the bridge's outgoing AXIS register. It accepts one word, emits it LSB-first over `NumBeats` handshaked beats, and marks the final beat with `last`. It sustains full throughput: no bubble cycles between consecutive words.

## Interface
- `DataWidth`, default 72: width of the incoming AXIS word (header + flit data).
- `BeatWidth`, default 16: width of one outgoing beat.
- `NumBeats` (localparam): `ceil(DataWidth/BeatWidth)`. Legal range is ≥1.
- `CntWidth` (localparam): `max(1, $clog2(NumBeats))`.
- `clk_i`, in, 1: clock, single domain.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `in_valid_i`, in, 1: wide word valid.
- `in_ready_o`, out, 1: wide word accepted when high together with `in_valid_i`.
- `in_data_i`, in, `DataWidth`: wide word.
- `out_valid_o`, out, 1: beat valid.
- `out_ready_i`, in, 1: downstream accepts beat.
- `out_data_o`, out, `BeatWidth`: current beat.
- `out_last_o`, out, 1: current beat is the final beat of the word.
- `out_idx_o`, out, `CntWidth`: index of the current beat, 0-based.
- `busy_o`, out, 1: a word is held (equals `out_valid_o`).

## Operation
- Internal storage:
  - shift register `sreg`, `NumBeats*BeatWidth` bits wide;
  - beat counter `cnt`;
  - state, either IDLE or SEND.
- Loading:
  - On an input handshake, `sreg` ← `in_data_i` zero-extended to `NumBeats*BeatWidth` bits, so the upper pad bits are 0.
  - `cnt` ← 0 and state ← SEND.
- Output path, all driven from registers:
  - `out_data_o = sreg[BeatWidth-1:0]`;
  - `out_idx_o = cnt`;
  - `out_last_o = (cnt == NumBeats-1)` while in SEND, and 0 in IDLE;
  - `out_valid_o = (state == SEND)`.
- Beat handshake, when `out_valid_o & out_ready_i`:
  - if not last: `sreg` shifts right by `BeatWidth` and `cnt` increments;
  - if last: the word is complete.
- Ready rule: `in_ready_o = (state == IDLE) | (out_valid_o & out_ready_i & out_last_o)`. The rule is combinational from `out_ready_i` only and never depends on `in_valid_i`.
- Transitions:
  - IDLE → SEND on an input handshake.
  - SEND → SEND on a last-beat handshake with a simultaneous input handshake. This is a reload: the new word is loaded and `cnt` goes to 0.
  - SEND → IDLE on a last-beat handshake with no input handshake.
  - Otherwise the state holds.
- `NumBeats == 1` degenerates to a one-deep pipeline register: `out_last_o` is constantly 1 in SEND, and no shifting occurs.
- Beat content is never modified. Pad bits appear only in the top of the last beat.

## Timing
- Reset, asynchronous, effective immediately:
  - `out_valid_o` = 0, `out_last_o` = 0, `out_idx_o` = 0, `busy_o` = 0;
  - `out_data_o` = 0 (`sreg` cleared);
  - state = IDLE, so `in_ready_o` = 1 as soon as reset is released.
- Reset during SEND discards the held word with no partial-beat output afterwards.
- Latency: a word accepted in cycle t presents beat 0 in cycle t+1.
- Throughput: one word every `NumBeats` cycles with `out_ready_i` held high. The next word's beat 0 directly follows the previous last beat.
- AXIS stability: while `out_valid_o & !out_ready_i`, the signals `out_data_o`, `out_last_o` and `out_idx_o` hold their values, and `out_valid_o` does not drop.
- Backpressure in SEND freezes `cnt` and `sreg`. `in_ready_o` stays 0 until the last beat is taken.
- `in_valid_i` may rise and fall freely. There is no requirement on upstream stability beyond the AXIS rule.

## Test plan
All scenarios use `DataWidth` = 72 and `BeatWidth` = 16, giving `NumBeats` = 5.
- Reset values: assert `rst_ni` = 0 mid-cycle → outputs go to 0 immediately. Release reset → `in_ready_o` = 1, `out_valid_o` = 0.
- Single word, no backpressure: word `0xAB_1234_5678_9ABC_DEF0` accepted at t0 → beats `0xDEF0`, `0x9ABC`, `0x5678`, `0x1234`, `0x00AB` at t1..t5. Indices are 0..4, and `out_last_o` = 1 only at t5. `in_ready_o` = 0 during t1..t4.
- Back-to-back words: two words offered continuously with `out_ready_i` = 1 → 10 beats in 10 consecutive cycles. The second word is accepted in the same cycle as the first word's last beat (t5), and `out_valid_o` never drops.
- Backpressure: `out_ready_i` low for 3 cycles during beat 2 → `0x5678` and `out_idx_o` = 2 are held stable for those 3 cycles. `in_ready_o` stays 0, and no beat is lost or duplicated.
- Reset mid-word: assert reset after beat 1 is taken → `out_valid_o` = 0 immediately. After release, a new word `0x00_0000_0000_0000_0001` yields beats `0x0001`, 0, 0, 0, 0 with no residue from the old word.
- Degenerate configuration: with `DataWidth` = `BeatWidth` = 16, word `0xBEEF` → one beat `0xBEEF` with `out_last_o` = 1. With continuous traffic, throughput is 1 word per cycle.
